lp_rx_seq_detector: RTL
=======================

Name: lp_rx_seq_detector

Overview:
Receive-side LP sequence detector for the C-PHY slave lane. It is the counterpart to the slave's LP transmit timing. It synchronises the incoming LP line levels and glitch-filters them against a minimum T_LPX dwell. It then tracks the Stop -> HS-Rqst -> HS-Prepare and Stop -> LP-Rqst -> Bridge -> Esc-Rqst -> Esc-Go entry sequences. It enables the HS receiver after T_HS-SETTLE, pulses escape entry, and flags malformed or stalled sequences.

Parameters:
MIN_LPX, 14, consecutive stable samples needed to qualify a line state (about 50 ns at 3.33 ns clk)
HS_SETTLE, 29, cycles in HS_PREPARE before HsRxEn asserts (about 100 ns)
SEQ_TIMEOUT, 3000, maximum cycles in any request/bridge state before abort (about 10 us)

Ports:
clk  input  1  receive clock
rst_n  input  1  reset, asynchronous, active-low
Enable  input  1  detector enable from lane control; low forces IDLE
LpState  input  2  raw asynchronous LP levels {LP_A, LP_B}
LineState  output  2  filtered, qualified line state
StopState  output  1  high while the FSM is in STOP
HsRxEn  output  1  HS receiver/termination enable
EscEntry  output  1  one-cycle pulse on valid escape entry
SeqError  output  1  one-cycle pulse on sequence violation or timeout

Behaviour:
- Reset values: LineState=2'b00, StopState=0, HsRxEn=0, EscEntry=0, SeqError=0. The FSM is in IDLE, all counters are 0, and the sync flops are 2'b00.
- Synchroniser: 2-flop sync on LpState gives s.
- Run counter:
  - run counts consecutive cycles s has held its value, including the current cycle. It resets to 1 on a change and saturates at 16'hFFFF.
  - On the edge where run reaches MIN_LPX, LineState <= s.
  - Net latency from a stable input change to LineState is MIN_LPX+2 cycles.
  - Pulses shorter than MIN_LPX samples never reach LineState.
- FSM: registered, evaluates LineState. Output effects appear on the same edge as the state change.
- Dwell counter: clears on every state change and counts cycles in the current state (16 bits, saturating).
- States and transitions (LineState values shown as binary):
  - IDLE: go to STOP when Enable=1 and LineState=11.
  - STOP: StopState=1.
    - 01 -> HS_RQST.
    - 10 -> LP_RQST.
    - 00 -> SeqError, WAIT_STOP.
  - HS_RQST:
    - 00 -> HS_PREPARE.
    - 11 -> STOP (aborted request, no error).
    - 10 -> SeqError, WAIT_STOP.
  - HS_PREPARE: settle counter starts at 0 on entry.
    - When the counter reaches HS_SETTLE-1 -> HS_RX with HsRxEn=1. HsRxEn therefore rises HS_SETTLE cycles after entry.
    - Any LineState other than 00 -> SeqError, WAIT_STOP.
  - HS_RX: HsRxEn=1.
    - Exit only on 11 -> STOP. HsRxEn drops on the same edge.
    - LineState 01 or 10 is ignored; the lines are undriven during HS.
  - LP_RQST:
    - 00 -> BRIDGE.
    - 11 -> STOP.
    - 01 -> SeqError, WAIT_STOP.
  - BRIDGE:
    - 01 -> ESC_RQST.
    - 10 -> TA_WAIT (turnaround request, handled by the turnaround block).
    - 11 -> STOP.
  - ESC_RQST:
    - 00 -> ESC_ACTIVE with EscEntry pulsed for 1 cycle.
    - 11 -> STOP.
    - 10 -> SeqError, WAIT_STOP.
  - ESC_ACTIVE and TA_WAIT: remain until 11 -> STOP.
  - WAIT_STOP: all outputs except LineState are 0; 11 -> STOP.
- Timeout: in HS_RQST, LP_RQST, BRIDGE or ESC_RQST, reaching SEQ_TIMEOUT dwell cycles -> SeqError pulse, WAIT_STOP. HS_RX, ESC_ACTIVE and TA_WAIT have no timeout.
- Enable low: on the next edge, go to IDLE; HsRxEn, StopState and pulses go to 0. The sync stage, run counter and LineState keep running.
- Async reset mid-sequence: all outputs return immediately to reset values, including HsRxEn low.
- If a transition and a timeout fall on the same cycle, the transition wins.
- SeqError and EscEntry are never high together.

Test Plan:
- Reset, Enable=1, LpState=11 held: LineState=11 at edge 16 (MIN_LPX+2), StopState=1 at edge 17; all other outputs 0.
- From STOP, drive 01 for 20 cycles then 00: FSM in HS_PREPARE, HsRxEn rises exactly 29 cycles later. Then drive 11: HsRxEn falls and StopState=1 one cycle after LineState becomes 11.
- From STOP, drive the sequence 10, 00, 01, 00, each held 20 cycles: exactly one EscEntry pulse and no SeqError. Then drive 11: StopState=1.
- Glitch: in STOP, 10-cycle 01 pulse (< MIN_LPX) -> LineState stays 11, no state change.
- Errors:
  - In HS_PREPARE, drive 10 for 20 cycles -> one SeqError pulse, WAIT_STOP, HsRxEn stays 0.
  - Separately, hold 01 in HS_RQST for SEQ_TIMEOUT cycles -> SeqError exactly at the timeout.
- Deassert Enable in HS_RX -> HsRxEn=0 on the next edge, IDLE. Assert rst_n=0 in ESC_ACTIVE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lp_rx_seq_detector.sv
// Receive-side LP sequence detector: synchronises and qualifies the LP line levels,
// then follows the HS-entry and escape-entry request sequences.
//
// state      | meaning
// IDLE       | detector disabled or waiting for the first Stop
// STOP       | LP-11 seen, lane at rest
// HS_RQST    | LP-01 after Stop, HS request
// HS_PREPARE | LP-00 after HS request, settle timer running
// HS_RX      | HS receiver enabled
// LP_RQST    | LP-10 after Stop, LP request
// BRIDGE     | LP-00 after LP request
// ESC_RQST   | LP-01 after bridge, escape request
// ESC_ACTIVE | escape mode entered
// TA_WAIT    | turnaround requested, owned by the turnaround block
// WAIT_STOP  | malformed or stalled sequence, waiting for Stop
module lp_rx_seq_detector #(
  parameter int MIN_LPX     = 14,
  parameter int HS_SETTLE   = 29,
  parameter int SEQ_TIMEOUT = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic [1:0] LpState,
  output logic [1:0] LineState,
  output logic       StopState,
  output logic       HsRxEn,
  output logic       EscEntry,
  output logic       SeqError
);

  localparam logic [15:0] RunQual     = 16'(MIN_LPX);
  localparam logic [15:0] SettleLast  = 16'(HS_SETTLE - 1);
  localparam logic [15:0] TimeoutLast = 16'(SEQ_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, STOP, HS_RQST, HS_PREPARE, HS_RX, LP_RQST,
    BRIDGE, ESC_RQST, ESC_ACTIVE, TA_WAIT, WAIT_STOP
  } state_e;

  logic [1:0]  sync1_q, sync2_q, s_prev_q, line_q;
  logic [15:0] run_q, run_d;
  state_e      state_q, state_d;
  logic [15:0] dwell_q, dwell_d;
  logic        esc_q, esc_d, err_q, err_d;
  logic        timeout;

  // run counts cycles the synchronised level has held, starting at 1 on a change
  always_comb begin
    if (sync2_q != s_prev_q)    run_d = 16'd1;
    else if (run_q == 16'hFFFF) run_d = run_q;
    else                        run_d = run_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      s_prev_q <= 2'b00;
      run_q    <= 16'd0;
      line_q   <= 2'b00;
    end else begin
      sync1_q  <= LpState;
      sync2_q  <= sync1_q;
      s_prev_q <= sync2_q;
      run_q    <= run_d;
      if (run_d == RunQual) line_q <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dwell_q <= 16'd0;
      esc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      esc_q   <= esc_d;
      err_q   <= err_d;
    end
  end

  // Legal line transitions are tested before the timeout so a transition wins a tie
  always_comb begin
    state_d = state_q;
    timeout = (dwell_q >= TimeoutLast);
    if (!Enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (line_q == 2'b11) state_d = STOP;
        STOP: begin
          case (line_q)
            2'b01:   state_d = HS_RQST;
            2'b10:   state_d = LP_RQST;
            2'b00:   state_d = WAIT_STOP;
            default: state_d = STOP;
          endcase
        end
        HS_RQST: begin
          case (line_q)
            2'b00:   state_d = HS_PREPARE;
            2'b11:   state_d = STOP;
            2'b10:   state_d = WAIT_STOP;
            default: if (timeout) state_d = WAIT_STOP;
          endcase
        end
        HS_PREPARE: begin
          if (line_q != 2'b00)          state_d = WAIT_STOP;
          else if (dwell_q >= SettleLast) state_d = HS_RX;
        end
        LP_RQST: begin
          case (line_q)
            2'b00:   state_d = BRIDGE;
            2'b11:   state_d = STOP;
            2'b01:   state_d = WAIT_STOP;
            default: if (timeout) state_d = WAIT_STOP;
          endcase
        end
        BRIDGE: begin
          case (line_q)
            2'b01:   state_d = ESC_RQST;
            2'b10:   state_d = TA_WAIT;
            2'b11:   state_d = STOP;
            default: if (timeout) state_d = WAIT_STOP;
          endcase
        end
        ESC_RQST: begin
          case (line_q)
            2'b00:   state_d = ESC_ACTIVE;
            2'b11:   state_d = STOP;
            2'b10:   state_d = WAIT_STOP;
            default: if (timeout) state_d = WAIT_STOP;
          endcase
        end
        HS_RX, ESC_ACTIVE, TA_WAIT, WAIT_STOP:
          if (line_q == 2'b11) state_d = STOP;
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q)     dwell_d = 16'd0;
    else if (dwell_q == 16'hFFFF) dwell_d = dwell_q;
    else                        dwell_d = dwell_q + 16'd1;
  end

  always_comb begin
    esc_d     = (state_q == ESC_RQST) && (state_d == ESC_ACTIVE);
    err_d     = (state_q != WAIT_STOP) && (state_d == WAIT_STOP);
    StopState = (state_q == STOP);
    HsRxEn    = (state_q == HS_RX);
  end

  assign LineState = line_q;
  assign EscEntry  = esc_q;
  assign SeqError  = err_q;

endmodule
